// File: rtl/reshape_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reshape_op_sequencer
// Description : Runs one reshape operation (concat/split/maxpool/upsample)
//               per command. Routes the input switch, masks the output
//               switch, kicks the DMA channels, starts the op, waits for
//               end-of-op and write completion, then clears the datapath.
//               A watchdog over RUN/DRAIN parks the sequencer in ERR.
// Revision    : 1.0 - initial release
// ============================================================================
module reshape_op_sequencer #(
  parameter int TIMEOUT_W = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Control_Reshape,
  input  logic       Abort,
  input  logic       Last_Reshape,
  input  logic       inter_reshape,
  output logic [1:0] dest,
  output logic [3:0] End_Control,
  output logic [3:0] Start_Reshape,
  output logic       DMA_read_valid,
  output logic       DMA_read_valid_2,
  output logic       DMA_write_valid,
  output logic       Next_Reg,
  output logic       Done,
  output logic       Cmd_Err,
  output logic       Timeout,
  output logic [7:0] ReshapeState
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CFG   = 4'd1,
    S_KICK  = 4'd2,
    S_START = 4'd3,
    S_RUN   = 4'd4,
    S_DRAIN = 4'd5,
    S_NEXT  = 4'd6,
    S_ERR   = 4'd7
  } state_t;

  localparam logic [3:0] c_ALL_OPEN = 4'hF;

  state_t               r_state;
  logic [TIMEOUT_W-1:0] r_wd;
  logic                 r_sticky;

  state_t               w_next;
  logic [TIMEOUT_W-1:0] w_wd_next;
  logic [TIMEOUT_W-1:0] w_wd_inc;
  logic                 w_wd_hit;
  logic                 w_sticky_next;
  logic                 w_onehot;
  logic [1:0]           w_cmd_dest;
  logic [1:0]           w_dest_next;
  logic [3:0]           w_end_next;
  logic [3:0]           w_start_next;
  logic                 w_done;
  logic                 w_cmd_err;

  // Status word is a pure view of registered state.
  assign ReshapeState = {dest, Timeout, (r_state != S_IDLE), r_state};

  // Next-state decode and next values for every registered output.
  always_comb begin
    w_next        = r_state;
    w_wd_next     = r_wd;
    w_sticky_next = r_sticky;
    w_done        = 1'b0;
    w_cmd_err     = 1'b0;
    w_dest_next   = dest;
    w_wd_inc      = r_wd + TIMEOUT_W'(1);
    w_wd_hit      = &w_wd_inc;
    w_onehot      = (Control_Reshape != 4'd0) &&
                    ((Control_Reshape & (Control_Reshape - 4'd1)) == 4'd0);
    w_cmd_dest    = {Control_Reshape[3] | Control_Reshape[2],
                     Control_Reshape[3] | Control_Reshape[1]};

    case (r_state)
      S_IDLE: begin
        if (w_onehot) begin
          w_next      = S_CFG;
          w_dest_next = w_cmd_dest;
        end else if (Control_Reshape != 4'd0) begin
          w_cmd_err = 1'b1;
        end
      end
      S_CFG:   w_next = S_KICK;
      S_KICK:  w_next = S_START;
      S_START: begin
        w_next        = S_RUN;
        w_wd_next     = '0;
        w_sticky_next = 1'b0;
      end
      S_RUN: begin
        w_wd_next = w_wd_inc;
        // End-of-op events beat the watchdog in the same cycle.
        if (Last_Reshape && (inter_reshape || r_sticky)) begin
          w_next = S_NEXT;
          w_done = 1'b1;
        end else if (Last_Reshape) begin
          w_next = S_DRAIN;
        end else if (w_wd_hit) begin
          w_next = S_ERR;
        end else if (inter_reshape) begin
          w_sticky_next = 1'b1;
        end
      end
      S_DRAIN: begin
        w_wd_next = w_wd_inc;
        if (inter_reshape) begin
          w_next = S_NEXT;
          w_done = 1'b1;
        end else if (w_wd_hit) begin
          w_next = S_ERR;
        end
      end
      S_NEXT: w_next = S_IDLE;
      S_ERR: begin
        if (Abort) w_next = S_NEXT;
      end
      default: w_next = S_IDLE;
    endcase

    // Abort abandons any in-flight op without reporting Done.
    if (Abort && (r_state inside {S_CFG, S_KICK, S_START, S_RUN, S_DRAIN})) begin
      w_next = S_NEXT;
      w_done = 1'b0;
    end

    // Any command while busy is refused, except during the clearing cycle.
    if ((Control_Reshape != 4'd0) && (r_state != S_IDLE) && (r_state != S_NEXT))
      w_cmd_err = 1'b1;

    // Mask opens fully in IDLE/ERR; NEXT reached from ERR keeps it open.
    if (w_next == S_IDLE || w_next == S_ERR)
      w_end_next = c_ALL_OPEN;
    else if (r_state == S_IDLE)
      w_end_next = ~(4'b0001 << w_cmd_dest);
    else
      w_end_next = End_Control;

    // Start bit order is rotated one place relative to dest.
    w_start_next = (w_next == S_START) ? (4'b0001 << (dest - 2'd1)) : 4'd0;
  end

  // State, watchdog and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state          <= S_IDLE;
      r_wd             <= '0;
      r_sticky         <= 1'b0;
      dest             <= 2'd0;
      End_Control      <= c_ALL_OPEN;
      Start_Reshape    <= 4'd0;
      DMA_read_valid   <= 1'b0;
      DMA_read_valid_2 <= 1'b0;
      DMA_write_valid  <= 1'b0;
      Next_Reg         <= 1'b0;
      Done             <= 1'b0;
      Cmd_Err          <= 1'b0;
      Timeout          <= 1'b0;
    end else begin
      r_state          <= w_next;
      r_wd             <= w_wd_next;
      r_sticky         <= w_sticky_next;
      dest             <= w_dest_next;
      End_Control      <= w_end_next;
      Start_Reshape    <= w_start_next;
      DMA_read_valid   <= (w_next == S_KICK);
      DMA_read_valid_2 <= (w_next == S_KICK) && (dest == 2'd0);
      DMA_write_valid  <= (w_next == S_KICK);
      Next_Reg         <= (w_next == S_NEXT);
      Done             <= w_done;
      Cmd_Err          <= w_cmd_err;
      Timeout          <= (w_next == S_ERR);
    end
  end

endmodule
`default_nettype wire
